// File: rtl/host_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : host_cmd_queue
//  Purpose  : Parses NoC command frames into a FIFO and dispatches them one
//             at a time to the flash transaction FSM.
//  Revision : 1.0 - initial release
// ============================================================================

module host_cmd_queue #(
    parameter int ADDR_BYTES = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int KEY_BYTES  = 32,
    parameter int TEXT_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          noc_valid,
    input  logic [7:0]                    noc_data,
    output logic                          noc_ready,
    input  logic                          busy_flag,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [1:0]                    cmd_opcode,
    output logic [8*ADDR_BYTES-1:0]       cmd_addr,
    output logic [LEN_WIDTH-1:0]          cmd_len,
    output logic                          cmd_enc_dec,
    output logic [1:0]                    cmd_source,
    output logic [1:0]                    cmd_dest,
    input  logic                          txn_done,
    output logic                          cmd_ack,
    output logic                          cmd_err,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_BEAT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int c_ADDR_W  = 8 * ADDR_BYTES;
    localparam int c_ENTRY_W = c_ADDR_W + 7;

    localparam logic [c_BEAT_W-1:0]  c_LAST_BEAT = c_BEAT_W'(ADDR_BYTES - 1);
    localparam logic [c_CNT_W-1:0]   c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] c_KEY_LEN   = LEN_WIDTH'(KEY_BYTES);
    localparam logic [LEN_WIDTH-1:0] c_TEXT_LEN  = LEN_WIDTH'(TEXT_BYTES);
    localparam logic [1:0]           c_OP_ILLEGAL = 2'b11;

    typedef enum logic [0:0] {
        P_HDR  = 1'b0,
        P_ADDR = 1'b1
    } parse_state_t;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } disp_state_t;

    // ------------------------------------------------------------------------
    // Parser state
    // ------------------------------------------------------------------------
    parse_state_t            p_state_q;
    logic [c_BEAT_W-1:0]     beat_q;
    logic                    enc_q;
    logic [1:0]              dst_q;
    logic [1:0]              src_q;
    logic [1:0]              op_q;
    logic [c_ADDR_W-1:0]     addr_q;
    logic                    err_q;

    logic [c_CNT_W-1:0]      count_q;
    logic [c_CNT_W-1:0]      count_d;
    logic [c_PTR_W-1:0]      wr_ptr_q;
    logic [c_PTR_W-1:0]      wr_ptr_d;
    logic [c_PTR_W-1:0]      rd_ptr_q;
    logic [c_PTR_W-1:0]      rd_ptr_d;
    logic [c_ENTRY_W-1:0]    mem_q [FIFO_DEPTH];

    disp_state_t             d_state_q;
    logic                    cmd_valid_q;
    logic                    ack_q;

    logic                    w_xfer;
    logic                    w_last;
    logic                    w_push;
    logic                    w_pop;
    logic [c_ADDR_W-1:0]     w_push_addr;
    logic [c_ENTRY_W-1:0]    w_entry;
    logic [c_ENTRY_W-1:0]    w_head;

    assign noc_ready = (count_q < c_DEPTH);
    assign w_xfer    = noc_valid && noc_ready;
    assign w_last    = (p_state_q == P_ADDR) && (beat_q == c_LAST_BEAT);
    assign w_push    = w_xfer && w_last && (op_q != c_OP_ILLEGAL);
    assign w_pop     = cmd_valid_q && cmd_ready;

    // The final address byte is still on the bus when the entry is written,
    // so merge it into the stored address combinationally.
    always_comb begin
        w_push_addr = addr_q;
        for (int k = 0; k < ADDR_BYTES; k++) begin
            if (beat_q == c_BEAT_W'(k)) begin
                w_push_addr[8*k +: 8] = noc_data;
            end
        end
    end

    assign w_entry = {enc_q, dst_q, src_q, op_q, w_push_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state_q <= P_HDR;
            beat_q    <= '0;
            enc_q     <= 1'b0;
            dst_q     <= 2'b00;
            src_q     <= 2'b00;
            op_q      <= 2'b00;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (w_xfer) begin
                case (p_state_q)
                    P_HDR: begin
                        enc_q     <= noc_data[7];
                        dst_q     <= noc_data[5:4];
                        src_q     <= noc_data[3:2];
                        op_q      <= noc_data[1:0];
                        beat_q    <= '0;
                        p_state_q <= P_ADDR;
                    end
                    P_ADDR: begin
                        addr_q <= w_push_addr;
                        if (beat_q == c_LAST_BEAT) begin
                            beat_q    <= '0;
                            p_state_q <= P_HDR;
                            err_q     <= (op_q == c_OP_ILLEGAL);
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                    default: p_state_q <= P_HDR;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Dispatcher: one command outstanding at a time
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_q   <= D_IDLE;
            cmd_valid_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (d_state_q)
                D_IDLE: begin
                    // Once offered, the command is held regardless of busy_flag.
                    if (cmd_valid_q) begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            d_state_q   <= D_WAIT;
                        end
                    end else if ((count_q != '0) && !busy_flag) begin
                        cmd_valid_q <= 1'b1;
                    end
                end
                D_WAIT: begin
                    if (txn_done) begin
                        ack_q     <= 1'b1;
                        d_state_q <= D_IDLE;
                    end
                end
                default: d_state_q <= D_IDLE;
            endcase
        end
    end

    assign w_head      = mem_q[rd_ptr_q];
    assign cmd_addr    = w_head[c_ADDR_W-1:0];
    assign cmd_opcode  = w_head[c_ADDR_W+1 -: 2];
    assign cmd_source  = w_head[c_ADDR_W+3 -: 2];
    assign cmd_dest    = w_head[c_ADDR_W+5 -: 2];
    assign cmd_enc_dec = w_head[c_ADDR_W+6];
    assign cmd_len     = (cmd_opcode == 2'b00) ? c_KEY_LEN : c_TEXT_LEN;

    assign cmd_valid   = cmd_valid_q;
    assign cmd_ack     = ack_q;
    assign cmd_err     = err_q;
    assign queue_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_host_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_host_cmd_queue
//  Purpose  : Directed scenarios plus a randomized run against a queue-based
//             reference model of host_cmd_queue.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_host_cmd_queue;

    localparam int ADDR_BYTES = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_WIDTH  = 8;
    localparam int KEY_BYTES  = 32;
    localparam int TEXT_BYTES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        noc_valid;
    logic [7:0]  noc_data;
    logic        noc_ready;
    logic        busy_flag;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_enc_dec;
    logic [1:0]  cmd_source;
    logic [1:0]  cmd_dest;
    logic        txn_done;
    logic        cmd_ack;
    logic        cmd_err;
    logic [2:0]  queue_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic        enc;
        logic [1:0]  src;
        logic [1:0]  dst;
    } cmd_t;

    host_cmd_queue #(
        .ADDR_BYTES (ADDR_BYTES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .KEY_BYTES  (KEY_BYTES),
        .TEXT_BYTES (TEXT_BYTES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .noc_valid   (noc_valid),
        .noc_data    (noc_data),
        .noc_ready   (noc_ready),
        .busy_flag   (busy_flag),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_enc_dec (cmd_enc_dec),
        .cmd_source  (cmd_source),
        .cmd_dest    (cmd_dest),
        .txn_done    (txn_done),
        .cmd_ack     (cmd_ack),
        .cmd_err     (cmd_err),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_len(input logic [1:0] op);
        return (op == 2'b00) ? 8'(KEY_BYTES) : 8'(TEXT_BYTES);
    endfunction

    task automatic idle_inputs();
        noc_valid = 1'b0;
        noc_data  = 8'h00;
        busy_flag = 1'b0;
        cmd_ready = 1'b0;
        txn_done  = 1'b0;
    endtask

    // Offers one byte and returns on the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        noc_valid = 1'b1;
        noc_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (noc_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        noc_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [23:0] addr, output bit ok);
        bit b;
        send_byte(hdr, ok);
        for (int k = 0; k < ADDR_BYTES; k++) begin
            send_byte(addr[8*k +: 8], b);
            ok = ok & b;
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        vectors++; if (cmd_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", cmd_ack); end
        vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", cmd_err); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (noc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", noc_ready); end
    endtask

    task automatic test_single();
        bit ok;
        cmd_ready = 1'b1;
        send_frame(8'h81, 24'h302010, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_send: frame not accepted"); end
        wait_valid(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_valid: cmd_valid never rose"); end
        vectors++; if (cmd_opcode !== 2'b01) begin miscompares++; $display("FAIL single_op: got %b want 01", cmd_opcode); end
        vectors++; if (cmd_addr !== 24'h302010) begin miscompares++; $display("FAIL single_addr: got %h want 302010", cmd_addr); end
        vectors++; if (cmd_len !== 8'd16) begin miscompares++; $display("FAIL single_len: got %0d want 16", cmd_len); end
        vectors++; if ({cmd_enc_dec, cmd_source, cmd_dest} !== 5'b1_00_00) begin miscompares++; $display("FAIL single_fields: got enc=%b src=%b dst=%b want 1/00/00", cmd_enc_dec, cmd_source, cmd_dest); end
        @(negedge clk);
        cmd_ready = 1'b0;
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL single_drop: got %b want 0", cmd_valid); end
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL single_pop: got %0d want 0", queue_count); end
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        vectors++; if (cmd_ack !== 1'b1) begin miscompares++; $display("FAIL single_ack: got %b want 1", cmd_ack); end
        @(negedge clk);
        vectors++; if (cmd_ack !== 1'b0) begin miscompares++; $display("FAIL single_ack_width: got %b want 0", cmd_ack); end
    endtask

    task automatic test_illegal();
        bit ok;
        bit seen;
        send_frame(8'h03, 24'h000000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL illegal_send: frame not consumed"); end
        vectors++; if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", cmd_err); end
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL illegal_count: got %0d want 0", queue_count); end
        @(negedge clk);
        vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_width: got %b want 0", cmd_err); end
        seen = 1'b0;
        repeat (6) begin
            if (cmd_valid || cmd_err || queue_count != 3'd0) seen = 1'b1;
            @(negedge clk);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL illegal_quiet: got activity=%b want 0", seen); end
    endtask

    task automatic test_full();
        bit ok;
        bit b;
        logic [7:0]  hdrs  [5];
        logic [23:0] addrs [5];
        for (int i = 0; i < 5; i++) begin
            hdrs[i]  = 8'($urandom) & 8'hFC;
            addrs[i] = 24'($urandom);
        end
        cmd_ready = 1'b0;
        busy_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(hdrs[i], addrs[i], ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL full_send%0d: frame not accepted", i); end
        end
        vectors++; if (queue_count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", queue_count); end
        noc_valid = 1'b1;
        noc_data  = hdrs[4];
        vectors++; if (noc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", noc_ready); end
        @(negedge clk);
        vectors++; if (noc_ready !== 1'b0 || queue_count !== 3'd4) begin miscompares++; $display("FAIL full_hold: got ready=%b count=%0d want 0/4", noc_ready, queue_count); end
        vectors++; if (cmd_valid !== 1'b1 || cmd_addr !== addrs[0]) begin miscompares++; $display("FAIL full_head: got valid=%b addr=%h want 1/%h", cmd_valid, cmd_addr, addrs[0]); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        vectors++; if (noc_ready !== 1'b1 || queue_count !== 3'd3) begin miscompares++; $display("FAIL full_after_pop: got ready=%b count=%0d want 1/3", noc_ready, queue_count); end
        @(negedge clk);
        noc_valid = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < ADDR_BYTES; k++) begin
            send_byte(addrs[4][8*k +: 8], b);
            ok = ok & b;
        end
        vectors++; if (!ok || queue_count !== 3'd4) begin miscompares++; $display("FAIL full_fifth: got ok=%b count=%0d want 1/4", ok, queue_count); end
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        vectors++; if (cmd_ack !== 1'b1) begin miscompares++; $display("FAIL full_ack: got %b want 1", cmd_ack); end
        for (int i = 1; i < 5; i++) begin
            wait_valid(20, ok);
            vectors++;
            if (!ok || cmd_addr !== addrs[i] || cmd_opcode !== 2'b00 || cmd_len !== 8'd32 ||
                cmd_enc_dec !== hdrs[i][7] || cmd_dest !== hdrs[i][5:4] || cmd_source !== hdrs[i][3:2]) begin
                miscompares++;
                $display("FAIL full_order%0d: got valid=%b addr=%h op=%b len=%0d want 1/%h/00/32", i, cmd_valid, cmd_addr, cmd_opcode, cmd_len, addrs[i]);
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            txn_done = 1'b1;
            @(negedge clk);
            txn_done = 1'b0;
        end
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", queue_count); end
    endtask

    task automatic test_busy();
        bit ok;
        bit seen;
        logic [23:0] a;
        a = 24'($urandom);
        busy_flag = 1'b1;
        send_frame(8'h35, a, ok);
        seen = 1'b0;
        repeat (4) begin
            if (cmd_valid) seen = 1'b1;
            @(negedge clk);
        end
        vectors++; if (!ok || seen || queue_count !== 3'd1) begin miscompares++; $display("FAIL busy_block: got ok=%b valid_seen=%b count=%0d want 1/0/1", ok, seen, queue_count); end
        busy_flag = 1'b0;
        @(negedge clk);
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL busy_release: got %b want 1", cmd_valid); end
        busy_flag = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_addr !== a || cmd_opcode !== 2'b01 || cmd_source !== 2'b01 || cmd_dest !== 2'b11) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL busy_hold: valid/fields changed, got valid=%b addr=%h want 1/%h", cmd_valid, cmd_addr, a); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        busy_flag = 1'b0;
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL busy_pop: got %b want 0", cmd_valid); end
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit b;
        cmd_ready = 1'b1;
        send_frame(8'h40, 24'h123456, ok);
        wait_valid(20, b);
        @(negedge clk);
        cmd_ready = 1'b0;
        send_byte(8'h01, b);
        send_byte(8'h11, b);
        send_byte(8'h22, b);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (queue_count !== 3'd0 || cmd_valid !== 1'b0 || cmd_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_clear: got count=%0d valid=%b ack=%b want 0/0/0", queue_count, cmd_valid, cmd_ack); end
        rst = 1'b0;
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        vectors++; if (cmd_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_noack: got %b want 0", cmd_ack); end
        send_frame(8'h42, 24'hCCBBAA, ok);
        wait_valid(20, b);
        vectors++;
        if (!ok || !b || cmd_opcode !== 2'b10 || cmd_addr !== 24'hCCBBAA || cmd_len !== 8'd16 ||
            cmd_enc_dec !== 1'b0 || cmd_source !== 2'b00 || cmd_dest !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_reparse: got valid=%b op=%b addr=%h len=%0d want 1/10/ccbbaa/16", cmd_valid, cmd_opcode, cmd_addr, cmd_len);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
    endtask

    task automatic test_done_idle();
        bit ok;
        bit b;
        logic [23:0] a2;
        a2 = 24'($urandom);
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        vectors++; if (cmd_ack !== 1'b0) begin miscompares++; $display("FAIL idle_done: got ack=%b want 0", cmd_ack); end
        cmd_ready = 1'b1;
        send_frame(8'h85, 24'h0A0B0C, ok);
        wait_valid(20, b);
        @(negedge clk);
        cmd_ready = 1'b0;
        send_byte(8'h0A, b);
        send_byte(a2[7:0], b);
        send_byte(a2[15:8], b);
        noc_valid = 1'b1;
        noc_data  = a2[23:16];
        txn_done  = 1'b1;
        vectors++; if (noc_ready !== 1'b1) begin miscompares++; $display("FAIL coincide_ready: got %b want 1", noc_ready); end
        @(negedge clk);
        noc_valid = 1'b0;
        txn_done  = 1'b0;
        vectors++; if (cmd_ack !== 1'b1 || queue_count !== 3'd1 || cmd_valid !== 1'b0) begin miscompares++; $display("FAIL coincide_ack: got ack=%b count=%0d valid=%b want 1/1/0", cmd_ack, queue_count, cmd_valid); end
        @(negedge clk);
        vectors++; if (cmd_valid !== 1'b1 || cmd_addr !== a2 || cmd_opcode !== 2'b10) begin miscompares++; $display("FAIL coincide_next: got valid=%b addr=%h op=%b want 1/%h/10", cmd_valid, cmd_addr, cmd_opcode, a2); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
    endtask

    // Cycle-level reference: a command queue plus the handshake rules.
    task automatic test_random();
        cmd_t        expq[$];
        logic [7:0]  bq[$];
        int          m_cnt;
        int          m_beat;
        bit          m_valid, m_outst, m_ack, m_err;
        bit          n_valid, n_ack, n_err, push, pop, xfer;
        logic [7:0]  m_hdr;
        logic [23:0] m_addr;
        cmd_t        e;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0; m_beat = 0; m_valid = 0; m_outst = 0; m_ack = 0; m_err = 0;
        m_hdr = 8'h00; m_addr = 24'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            vectors++; if (cmd_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, cmd_valid, m_valid); end
            vectors++; if (cmd_ack !== m_ack) begin miscompares++; $display("FAIL rnd_ack @%0d: got %b want %b", cyc, cmd_ack, m_ack); end
            vectors++; if (cmd_err !== m_err) begin miscompares++; $display("FAIL rnd_err @%0d: got %b want %b", cyc, cmd_err, m_err); end
            vectors++; if (queue_count !== 3'(m_cnt)) begin miscompares++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, queue_count, m_cnt); end
            vectors++; if (noc_ready !== (m_cnt < FIFO_DEPTH)) begin miscompares++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, noc_ready, m_cnt < FIFO_DEPTH); end

            if (cyc < 1440) begin
                if (bq.size() == 0) begin
                    logic [7:0] h;
                    h = 8'($urandom);
                    h[1:0] = ($urandom % 6 == 0) ? 2'b11 : 2'($urandom % 3);
                    bq.push_back(h);
                    for (int k = 0; k < ADDR_BYTES; k++) bq.push_back(8'($urandom));
                end
                noc_valid = ($urandom % 10) < 7;
                noc_data  = bq[0];
                cmd_ready = ((cyc / 200) % 2 == 1) ? ($urandom % 6 == 0) : ($urandom % 3 != 0);
                busy_flag = ($urandom % 4 == 0);
                txn_done  = ($urandom % 3 == 0);
            end else begin
                noc_valid = 1'b0;
                cmd_ready = 1'b1;
                busy_flag = 1'b0;
                txn_done  = 1'b1;
            end

            pop = m_valid && cmd_ready;
            if (cmd_valid && cmd_ready) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_pop_empty @%0d: got dispatch addr=%h want none", cyc, cmd_addr);
                end else if (cmd_opcode !== expq[0].op || cmd_addr !== expq[0].addr || cmd_len !== exp_len(expq[0].op) ||
                             cmd_enc_dec !== expq[0].enc || cmd_source !== expq[0].src || cmd_dest !== expq[0].dst) begin
                    miscompares++;
                    $display("FAIL rnd_fields @%0d: got op=%b addr=%h len=%0d enc=%b src=%b dst=%b want op=%b addr=%h len=%0d enc=%b src=%b dst=%b",
                             cyc, cmd_opcode, cmd_addr, cmd_len, cmd_enc_dec, cmd_source, cmd_dest,
                             expq[0].op, expq[0].addr, exp_len(expq[0].op), expq[0].enc, expq[0].src, expq[0].dst);
                end
            end

            xfer  = noc_valid && (m_cnt < FIFO_DEPTH);
            push  = 1'b0;
            n_err = 1'b0;
            if (xfer) begin
                if (m_beat == 0) m_hdr = noc_data;
                else m_addr[8*(m_beat-1) +: 8] = noc_data;
                void'(bq.pop_front());
                if (m_beat == ADDR_BYTES) begin
                    m_beat = 0;
                    if (m_hdr[1:0] == 2'b11) begin
                        n_err = 1'b1;
                    end else begin
                        push  = 1'b1;
                        e.op  = m_hdr[1:0];
                        e.addr = m_addr;
                        e.enc = m_hdr[7];
                        e.src = m_hdr[3:2];
                        e.dst = m_hdr[5:4];
                    end
                end else begin
                    m_beat++;
                end
            end
            n_ack   = m_outst && txn_done;
            n_valid = m_valid ? !cmd_ready : (!m_outst && m_cnt > 0 && !busy_flag);
            m_outst = pop ? 1'b1 : (n_ack ? 1'b0 : m_outst);
            if (pop && expq.size() > 0) void'(expq.pop_front());
            if (push) expq.push_back(e);
            m_cnt   = m_cnt + int'(push) - int'(pop);
            m_valid = n_valid;
            m_ack   = n_ack;
            m_err   = n_err;
            @(negedge clk);
        end
        vectors++; if (expq.size() != 0) begin miscompares++; $display("FAIL rnd_leftover: got %0d undispatched want 0", expq.size()); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_illegal();
        test_full();
        test_busy();
        test_reset_midframe();
        test_done_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/host_cmd_queue.md
HOST_CMD_QUEUE -- requirements
Module: host_cmd_queue

Interface
REQ-001 Parameters SHALL be:
- ADDR_BYTES, 3: flash address bytes per command frame.
- FIFO_DEPTH, 4: command queue entries; power of two, at least 2.
- LEN_WIDTH, 8: width of cmd_len.
- KEY_BYTES, 32: transfer length for RD_KEY.
- TEXT_BYTES, 16: transfer length for RD_TEXT and WR_RES.

REQ-002 Ports SHALL be (the design uses one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- noc_valid  in  1  NoC byte valid.
- noc_data  in  8  NoC byte.
- noc_ready  out  1  NoC byte accepted when high together with noc_valid.
- busy_flag  in  1  flash busy, from the status poller.
- cmd_valid  out  1  queued command offered to the transaction FSM.
- cmd_ready  in  1  transaction FSM accepts the command.
- cmd_opcode  out  2  00 RD_KEY, 01 RD_TEXT, 10 WR_RES.
- cmd_addr  out  8*ADDR_BYTES  flash address.
- cmd_len  out  LEN_WIDTH  transfer length in bytes.
- cmd_enc_dec  out  1  encrypt/decrypt flag, copied from the header.
- cmd_source  out  2  header source field.
- cmd_dest  out  2  header dest field.
- txn_done  in  1  transaction FSM finished the dispatched command.
- cmd_ack  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle pulse for an illegal frame.
- queue_count  out  clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-003 A frame SHALL be one header byte followed by ADDR_BYTES address bytes; a byte transfers on a cycle where noc_valid and noc_ready are both 1.
REQ-004 Header fields SHALL be: [7] enc_dec, [6] reserved (ignored), [5:4] dest, [3:2] source, [1:0] opcode.
REQ-005 The parser FSM SHALL have two states, P_HDR and P_ADDR, plus a beat counter; P_HDR goes to P_ADDR on header transfer; P_ADDR returns to P_HDR on transfer of address byte ADDR_BYTES-1.
REQ-006 Address bytes SHALL be little-endian: beat k loads cmd_addr[8k+7:8k].
REQ-007 noc_ready SHALL equal (queue_count < FIFO_DEPTH) in both parser states; the parser SHALL NOT accept bytes while the queue is full.
REQ-008 On the final address transfer, a legal frame SHALL be pushed on that same edge; queue_count SHALL increase in the following cycle.
REQ-009 cmd_len for the pushed entry SHALL be KEY_BYTES for opcode 00 and TEXT_BYTES for 01 or 10, truncated to LEN_WIDTH.
REQ-010 A frame with opcode 11 SHALL be fully consumed and SHALL NOT be pushed; cmd_err SHALL pulse for exactly one cycle, on the cycle after the final address byte.
REQ-011 The dispatcher FSM SHALL have two states, D_IDLE and D_WAIT.
REQ-012 cmd_valid SHALL rise, registered, in D_IDLE when the queue is non-empty and busy_flag is 0.
REQ-013 Once cmd_valid is high, it and all cmd_* fields SHALL stay stable until cmd_ready is 1, independent of busy_flag.
REQ-014 On cmd_valid and cmd_ready both high: the head entry SHALL pop, cmd_valid SHALL drop the next cycle, and the dispatcher SHALL enter D_WAIT.
REQ-015 In D_WAIT, txn_done SHALL cause a cmd_ack pulse on the next cycle and a return to D_IDLE; txn_done in D_IDLE SHALL be ignored.
REQ-016 At most one command SHALL be outstanding; the earliest a new cmd_valid can rise is the cycle after cmd_ack.
REQ-017 A push and a pop on the same edge SHALL leave queue_count unchanged; the queue SHALL preserve FIFO order with pointer wrap at FIFO_DEPTH.
REQ-018 cmd_* fields SHALL show the queue head; when cmd_valid is 0 their values are don't-care.

Reset
REQ-019 While rst is 1, the following SHALL be cleared: parser to P_HDR, beat counter 0, dispatcher to D_IDLE, pointers 0, and queue_count, cmd_valid, cmd_ack, cmd_err all 0.
REQ-020 After rst is released, noc_ready SHALL be 1.
REQ-021 A reset during a frame or during D_WAIT SHALL discard the partial frame and the outstanding command, with no cmd_ack.

Verification
REQ-022 Frame 0x81,0x10,0x20,0x30 with cmd_ready=1 -> cmd_valid, opcode 01, addr 0x302010, len 16, enc_dec 1, source 0, dest 0; txn_done -> cmd_ack exactly one cycle.
REQ-023 Frame 0x03,0x00,0x00,0x00 -> cmd_err single pulse, queue_count stays 0, no cmd_valid.
REQ-024 Five RD_KEY frames back-to-back with cmd_ready=0 -> queue_count reaches 4, noc_ready=0 at the fifth header; the fifth is accepted after the first pop; order is preserved.
REQ-025 busy_flag=1 with one queued entry -> cmd_valid stays 0; busy_flag falls -> cmd_valid next cycle; busy_flag rising again while valid is high -> valid held.
REQ-026 Assert rst after 2 address bytes -> queue_count 0; next full frame parses correctly, with no leftover beats.
REQ-027 txn_done pulsed while in D_IDLE -> no cmd_ack; txn_done coinciding with a push -> cmd_ack, and the new entry dispatches after it.
